int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_if.sv | 41 ++++
 rtl/int_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if -- register bus between a bus master and the interrupt controller
//
// Signals:
//   bus_addr   [7:0]  byte address (word aligned, bits [1:0] ignored)
//   bus_we            write strobe, one cycle per access
//   bus_re            read strobe, one cycle per access
//   bus_wdata  [31:0] write data
//   bus_rdata  [31:0] registered read data, zero except while bus_ack=1
//   bus_ack           one-cycle completion pulse, one cycle after a strobe
//
// Modports:
//   master -- drives address, strobes and write data
//   slave  -- the controller; drives read data and acknowledge
// -----------------------------------------------------------------------------
interface int_ctrl_if;
  logic [7:0]  bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr,
    output bus_we,
    output bus_re,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_addr,
    input  bus_we,
    input  bus_re,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- interrupt controller with 8 external level sources and a 64-bit
// machine timer, merged into a single registered interrupt line.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   irq_src    in   [7:0] level interrupt sources (synchronous to clk),
//                   source id = bit index + 1
//   bus        slave modport of int_ctrl_if (register access)
//   interrupt  out  registered (timer_pend | ext_pend)
//
// Register map (word offsets, anything at or above 0x20 reads 0 / ignores
// writes but is still acknowledged):
//   0x00 PENDING      RO  [7:0]
//   0x04 ENABLE       RW  [7:0]
//   0x08 CLAIM        R   id of lowest enabled pending source (0 if none);
//                         a nonzero claim moves the source pending->in_service
//        COMPLETE     W   wdata[3:0]=id releases that source from in_service
//   0x0C MTIME_LO     RW
//   0x10 MTIME_HI     RW
//   0x14 MTIMECMP_LO  RW
//   0x18 MTIMECMP_HI  RW
//   0x1C CTRL         RW  bit0 timer_en, bit1 ext_en
// -----------------------------------------------------------------------------
module int_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq_src,
  int_ctrl_if.slave   bus,
  output logic        interrupt
);

  localparam logic [2:0] A_PENDING  = 3'd0;
  localparam logic [2:0] A_ENABLE   = 3'd1;
  localparam logic [2:0] A_CLAIM    = 3'd2;
  localparam logic [2:0] A_MTIME_LO = 3'd3;
  localparam logic [2:0] A_MTIME_HI = 3'd4;
  localparam logic [2:0] A_CMP_LO   = 3'd5;
  localparam logic [2:0] A_CMP_HI   = 3'd6;
  localparam logic [2:0] A_CTRL     = 3'd7;

  // Lowest-index requesting source wins; result is id (1..8) or 0.
  function automatic logic [3:0] f_claim_id(input logic [7:0] req);
    logic [3:0] id;
    id = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) id = 4'(i + 1);
    end
    return id;
  endfunction

  // Decode a source id into a one-hot bit mask; 0 and ids above 8 give 0.
  function automatic logic [7:0] f_id_mask(input logic [3:0] id);
    logic [7:0] m;
    m = 8'd0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (id == 4'(i + 1));
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]  r_pending;
  logic [7:0]  r_in_service;
  logic [7:0]  r_enable;
  logic [1:0]  r_ctrl;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_interrupt;
  logic        r_ack;
  logic [31:0] r_rdata;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        w_mapped;
  logic [2:0]  w_word;
  logic        w_wr;
  logic        w_rd;
  logic [7:0]  w_wr_sel;
  logic        w_unused_addr;

  assign w_word   = bus.bus_addr[4:2];
  assign w_mapped = (bus.bus_addr[7:5] == 3'd0);
  assign w_wr     = bus.bus_we & w_mapped;
  // A simultaneous write takes precedence: the read half has no side effects.
  assign w_rd     = bus.bus_re & ~bus.bus_we;
  assign w_unused_addr = ^bus.bus_addr[1:0];

  always_comb begin
    w_wr_sel = 8'd0;
    if (w_wr) w_wr_sel[w_word] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Claim / complete
  // ---------------------------------------------------------------------------
  logic [3:0]  w_claim_id;
  logic        w_claim;
  logic [7:0]  w_claim_mask;
  logic [7:0]  w_complete_mask;
  logic [7:0]  w_pending_nxt;
  logic [7:0]  w_in_service_nxt;

  assign w_claim_id      = f_claim_id(r_pending & r_enable);
  assign w_claim         = w_rd & w_mapped & (w_word == A_CLAIM) & (w_claim_id != 4'd0);
  assign w_claim_mask    = w_claim ? f_id_mask(w_claim_id) : 8'd0;
  assign w_complete_mask = w_wr_sel[A_CLAIM] ? f_id_mask(bus.bus_wdata[3:0]) : 8'd0;

  // Setting looks at the in_service value before this edge, so a source
  // completed this edge re-pends one edge later, and a claim always wins
  // over a fresh assertion of the same source.
  assign w_pending_nxt    = (r_pending | (irq_src & ~r_in_service)) & ~w_claim_mask;
  assign w_in_service_nxt = (r_in_service | w_claim_mask) & ~w_complete_mask;

  // ---------------------------------------------------------------------------
  // Interrupt condition
  // ---------------------------------------------------------------------------
  logic w_timer_pend;
  logic w_ext_pend;

  assign w_timer_pend = r_ctrl[0] & (r_mtime >= r_mtimecmp);
  assign w_ext_pend   = r_ctrl[1] & (|(r_pending & r_enable));

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_rd_mux;

  always_comb begin
    w_rd_mux = 32'd0;
    if (w_mapped) begin
      case (w_word)
        A_PENDING:  w_rd_mux = {24'd0, r_pending};
        A_ENABLE:   w_rd_mux = {24'd0, r_enable};
        A_CLAIM:    w_rd_mux = {28'd0, w_claim_id};
        A_MTIME_LO: w_rd_mux = r_mtime[31:0];
        A_MTIME_HI: w_rd_mux = r_mtime[63:32];
        A_CMP_LO:   w_rd_mux = r_mtimecmp[31:0];
        A_CMP_HI:   w_rd_mux = r_mtimecmp[63:32];
        A_CTRL:     w_rd_mux = {30'd0, r_ctrl};
        default:    w_rd_mux = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Source tracking and configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= 8'd0;
      r_in_service <= 8'd0;
      r_enable     <= 8'd0;
      r_ctrl       <= 2'd0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
      if (w_wr_sel[A_ENABLE]) r_enable <= bus.bus_wdata[7:0];
      if (w_wr_sel[A_CTRL])   r_ctrl   <= bus.bus_wdata[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Machine timer: a write to either half replaces that half and skips the
  // increment for this cycle, so no carry leaks into the other half.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= {64{1'b1}};
    end else begin
      if (w_wr_sel[A_MTIME_LO]) begin
        r_mtime[31:0] <= bus.bus_wdata;
      end else if (w_wr_sel[A_MTIME_HI]) begin
        r_mtime[63:32] <= bus.bus_wdata;
      end else if (r_ctrl[0]) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_wr_sel[A_CMP_LO]) r_mtimecmp[31:0]  <= bus.bus_wdata;
      if (w_wr_sel[A_CMP_HI]) r_mtimecmp[63:32] <= bus.bus_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_interrupt <= 1'b0;
      r_ack       <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_interrupt <= w_timer_pend | w_ext_pend;
      r_ack       <= bus.bus_we | bus.bus_re;
      r_rdata     <= w_rd ? w_rd_mux : 32'd0;
    end
  end

  assign interrupt     = r_interrupt;
  assign bus.bus_ack   = r_ack;
  assign bus.bus_rdata = r_rdata;

endmodule
